// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 16;
    localparam int FIFO_DEF_DEPTH = 16;

    // Occupancy needs one more code than there are entries.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer bus of the parametrised FIFO.
interface param_fifo_if #(
    parameter int WIDTH = fifo_pkg::FIFO_DEF_WIDTH,
    parameter int DEPTH = fifo_pkg::FIFO_DEF_DEPTH
);
    localparam int CW = fifo_pkg::cnt_w(DEPTH);

    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_write;
    logic             fifo_read;
    logic             fifo_clr_err;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_data_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_almost_full;
    logic             fifo_almost_empty;
    logic [CW-1:0]    fifo_count;
    logic             fifo_overflow;
    logic             fifo_underflow;

    modport master (
        output fifo_data_in, fifo_write, fifo_read, fifo_clr_err,
        input  fifo_data_out, fifo_data_valid, fifo_full, fifo_empty,
        input  fifo_almost_full, fifo_almost_empty, fifo_count,
        input  fifo_overflow, fifo_underflow
    );

    modport slave (
        input  fifo_data_in, fifo_write, fifo_read, fifo_clr_err,
        output fifo_data_out, fifo_data_valid, fifo_full, fifo_empty,
        output fifo_almost_full, fifo_almost_empty, fifo_count,
        output fifo_overflow, fifo_underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags,
// sticky errors and standard or first-word-fall-through output.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic         clk,
    input logic         rst,
    param_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd_ok = bus.fifo_read && !w_empty;
    // A write into a full FIFO is fine if a read frees a slot.
    assign w_wr_ok = bus.fifo_write && (!w_full || w_rd_ok);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.fifo_data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_ok && !w_rd_ok)
                r_count <= r_count + 1'b1;
            else if (w_rd_ok && !w_wr_ok)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.fifo_write && !w_wr_ok)
                r_ovf <= 1'b1;
            else if (bus.fifo_clr_err)
                r_ovf <= 1'b0;
            if (bus.fifo_read && w_empty)
                r_udf <= 1'b1;
            else if (bus.fifo_clr_err)
                r_udf <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.fifo_data_out   = w_empty ? '0 : w_head;
            assign bus.fifo_data_valid = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else if (w_rd_ok) begin
                    r_dout  <= w_head;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            assign bus.fifo_data_out   = r_dout;
            assign bus.fifo_data_valid = r_valid;
        end
    endgenerate

    assign bus.fifo_full         = w_full;
    assign bus.fifo_empty        = w_empty;
    assign bus.fifo_almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.fifo_almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.fifo_count        = r_count;
    assign bus.fifo_overflow     = r_ovf;
    assign bus.fifo_underflow    = r_udf;

endmodule
